// File: rtl/fpga_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// fpga_apb_cmd_master
//   APB3 initiator. Commands arrive on a valid/ready stream, are buffered in a
//   small FIFO and issued in order as APB transfers on per_clk. Every issued
//   command produces exactly one single-cycle response (read data or error).
//
//   Optional feature macro: APB_MST_TIMEOUT_EN
//     When defined, an ACCESS phase that waits TO_CYC cycles without pready is
//     aborted and reported as an error. When undefined, the master waits in
//     ACCESS for as long as the responder holds pready low.
// -----------------------------------------------------------------------------
module fpga_apb_cmd_master #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYC     = 255
) (
  input  logic              per_clk,
  input  logic              clkrst_b,
  // command stream
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response stream
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  // APB initiator
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO: pointers carry an extra wrap bit so full and empty can be
  // told apart when the index bits match.
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q;
  logic [PTR_W:0]   rd_ptr_d;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic [ENT_W-1:0] head_s;
  logic             head_write_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [DATA_W-1:0] head_wdata_s;

  // Full is derived from registered pointers only, so a same-cycle pop never
  // opens room for a push into a full FIFO.
  assign full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign push_s  = cmd_vld && !full_s;
  assign cmd_rdy = !full_s;

  assign head_s       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_write_s = head_s[ENT_W-1];
  assign head_addr_s  = head_s[ADDR_W+DATA_W-1:DATA_W];
  assign head_wdata_s = head_s[DATA_W-1:0];

  // Next FIFO pointer values from push/pop strobes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // FIFO pointer registers.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; entries are cleared on reset so no stale command survives.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer control
  // ---------------------------------------------------------------------------
  state_e            state_q;
  state_e            state_d;
  logic              end_s;       // ACCESS finishes at this edge
  logic              to_abort_s;  // ACCESS abandoned because of wait limit

  logic              psel_q,     psel_d;
  logic              penable_q,  penable_d;
  logic              pwrite_q,   pwrite_d;
  logic [ADDR_W-1:0] paddr_q,    paddr_d;
  logic [DATA_W-1:0] pwdata_q,   pwdata_d;
  logic              rsp_vld_q,  rsp_vld_d;
  logic              rsp_err_q,  rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MST_TIMEOUT_EN
  localparam logic [7:0] TO_CNT_LIM = 8'(TO_CYC);

  logic [7:0] to_cnt_q;
  logic [7:0] to_cnt_d;

  // pready at the limit cycle takes priority over the abort.
  assign to_abort_s = (state_q == ST_ACCESS) && !pready && (to_cnt_q == TO_CNT_LIM);

  // Wait counter: cleared while in SETUP (i.e. on entry to ACCESS), counts
  // every ACCESS cycle in which the responder is not ready.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_SETUP) begin
      to_cnt_d = 8'd0;
    end else if ((state_q == ST_ACCESS) && !pready && !to_abort_s) begin
      to_cnt_d = to_cnt_q + 8'd1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      to_cnt_q <= 8'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic [7:0] unused_to_cyc_s;

  assign unused_to_cyc_s = 8'(TO_CYC);
  assign to_abort_s      = 1'b0;
`endif

  assign end_s = (state_q == ST_ACCESS) && (pready || to_abort_s);

  // FSM state register.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (end_s) begin
          if (!empty_s) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered APB and response outputs,
  // plus the FIFO pop strobe.
  always_comb begin
    pop_s       = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_vld_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = head_write_s;
          paddr_d   = head_addr_s;
          if (head_write_s) begin
            pwdata_d = head_wdata_s;
          end else begin
            pwdata_d = pwdata_q;
          end
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (end_s) begin
          rsp_vld_d = 1'b1;
          if (pready) begin
            rsp_err_d = pslverr;
            if (!pwrite_q && !pslverr) begin
              rsp_rdata_d = prdata;
            end else begin
              rsp_rdata_d = '0;
            end
          end else begin
            // wait limit reached
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
          if (!empty_s) begin
            // back-to-back: stay selected and start the next SETUP
            pop_s     = 1'b1;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = head_write_s;
            paddr_d   = head_addr_s;
            if (head_write_s) begin
              pwdata_d = head_wdata_s;
            end else begin
              pwdata_d = pwdata_q;
            end
          end else begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
          end
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Output registers for the APB bus and the response pulse.
  always_ff @(posedge per_clk or negedge clkrst_b) begin
    if (!clkrst_b) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_vld   = rsp_vld_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = !empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpga_apb_cmd_master.sv
// -----------------------------------------------------------------------------
// Testbench for fpga_apb_cmd_master. The bench plays the command source and
// the APB responder; it predicts bus phases, FIFO occupancy and responses
// from the command list and the responder's own wait/error choices.
// -----------------------------------------------------------------------------
module tb_fpga_apb_cmd_master;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TO_CYC = 8;
`ifdef APB_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              per_clk = 1'b0;
  logic              clkrst_b = 1'b1;
  logic              cmd_vld = 1'b0;
  logic              cmd_rdy;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;

  fpga_apb_cmd_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TO_CYC(TO_CYC)
  ) dut (
    .per_clk(per_clk), .clkrst_b(clkrst_b),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 per_clk = ~per_clk;

  typedef struct {
    logic              w;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                waits;   // ACCESS cycles with pready low before ready
    logic              err;     // pslverr returned with pready
    logic [DATA_W-1:0] rdata;   // prdata returned with pready
  } cmd_t;

  cmd_t              pend[$];        // accepted, not yet issued
  cmd_t              cur;            // transfer on the bus
  int                checks = 0;
  int                errors = 0;
  int                prev_ph = 0;    // 0 idle, 1 setup, 2 access
  logic              done_prev = 1'b0;
  logic              exp_err = 1'b0;
  logic [DATA_W-1:0] exp_rdata = '0;
  logic [DATA_W-1:0] last_wdata = '0;
  int                acc_cyc = 0;
  int                n_timeouts = 0;
  int                stall_cnt = 0;
  logic              last_acc = 1'b0;
  int                nx_waits = 0;
  logic              nx_err = 1'b0;
  logic [DATA_W-1:0] nx_rdata = '0;

  task automatic check(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: account the push at this edge, check the DUT after the
  // edge, then choose the responder inputs for the next edge.
  task automatic tick();
    logic acc;
    cmd_t c;
    int   occ_b;
    int   ph;
    acc     = cmd_vld && cmd_rdy;
    if (cmd_vld && !cmd_rdy) stall_cnt++;
    c.w     = cmd_write;
    c.addr  = cmd_addr;
    c.wdata = cmd_wdata;
    c.waits = nx_waits;
    c.err   = nx_err;
    c.rdata = nx_rdata;
    occ_b   = pend.size();
    @(negedge per_clk);
    case (prev_ph)
      0:       ph = (occ_b > 0) ? 1 : 0;
      1:       ph = 2;
      2:       ph = done_prev ? ((occ_b > 0) ? 1 : 0) : 2;
      default: ph = 0;
    endcase
    check({63'd0, rsp_vld}, {63'd0, done_prev}, "rsp_vld");
    if (done_prev) begin
      check({63'd0, rsp_err}, {63'd0, exp_err}, "rsp_err");
      check({32'd0, rsp_rdata}, {32'd0, exp_rdata}, "rsp_rdata");
    end
    check({63'd0, psel}, {63'd0, (ph != 0)}, "psel");
    check({63'd0, penable}, {63'd0, (ph == 2)}, "penable");
    if (ph == 1 && pend.size() > 0) begin
      cur     = pend.pop_front();
      acc_cyc = 0;
      if (cur.w) last_wdata = cur.wdata;
    end
    if (ph != 0) begin
      check({52'd0, paddr}, {52'd0, cur.addr}, "paddr");
      check({63'd0, pwrite}, {63'd0, cur.w}, "pwrite");
      check({32'd0, pwdata}, {32'd0, last_wdata}, "pwdata");
    end
    if (acc) pend.push_back(c);
    last_acc = acc;
    check({63'd0, cmd_rdy}, {63'd0, (pend.size() < DEPTH)}, "cmd_rdy");
    check({63'd0, busy}, {63'd0, (pend.size() > 0 || ph != 0)}, "busy");
    done_prev = 1'b0;
    if (ph == 2) begin
      acc_cyc++;
      if (acc_cyc > cur.waits) begin
        pready    = 1'b1;
        prdata    = cur.rdata;
        pslverr   = cur.err;
        done_prev = 1'b1;
        exp_err   = cur.err;
        exp_rdata = (!cur.w && !cur.err) ? cur.rdata : '0;
      end else if (TO_EN && acc_cyc == TO_CYC + 1) begin
        pready    = 1'b0;
        prdata    = $urandom;
        pslverr   = 1'($urandom);
        done_prev = 1'b1;
        exp_err   = 1'b1;
        exp_rdata = '0;
        n_timeouts++;
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
    end else begin
      pready  = 1'($urandom);
      prdata  = $urandom;
      pslverr = 1'($urandom);
    end
    prev_ph = ph;
  endtask

  task automatic push_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int waits, input logic err, input logic [DATA_W-1:0] rd);
    int n;
    cmd_vld   = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    nx_waits  = waits;
    nx_err    = err;
    nx_rdata  = rd;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 300) begin
      tick();
      n++;
    end
    check({63'd0, last_acc}, 64'd1, "push_accept_bound");
    cmd_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(pend.size() == 0 && prev_ph == 0 && !done_prev) && n < 1000) begin
      tick();
      n++;
    end
    check({63'd0, (pend.size() == 0 && prev_ph == 0 && !done_prev)}, 64'd1, "drain_bound");
  endtask

  initial begin
    int n;
    // reset state
    #1 clkrst_b = 1'b0;
    #1;
    check({63'd0, psel}, 64'd0, "rst_psel");
    check({63'd0, penable}, 64'd0, "rst_penable");
    check({63'd0, pwrite}, 64'd0, "rst_pwrite");
    check({52'd0, paddr}, 64'd0, "rst_paddr");
    check({32'd0, pwdata}, 64'd0, "rst_pwdata");
    check({63'd0, rsp_vld}, 64'd0, "rst_rsp_vld");
    check({63'd0, rsp_err}, 64'd0, "rst_rsp_err");
    check({32'd0, rsp_rdata}, 64'd0, "rst_rsp_rdata");
    check({63'd0, busy}, 64'd0, "rst_busy");
    @(negedge per_clk);
    clkrst_b = 1'b1;
    #1 check({63'd0, cmd_rdy}, 64'd1, "rst_cmd_rdy");

    // zero-wait write
    push_cmd(1'b1, 12'h010, 32'h0000_0005, 0, 1'b0, 32'h0);
    drain();
    // read with three wait states
    push_cmd(1'b0, 12'h020, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
    drain();
    // back-to-back transfers with the FIFO filling up
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      push_cmd(i[0], 12'(12'h100 + 12'(i * 4)), 32'(32'hA000_0000 + 32'(i)), 6, 1'b0, 32'(32'h5000_0000 + 32'(i)));
    end
    drain();
    check({63'd0, (stall_cnt > 0)}, 64'd1, "full_stall_seen");
    // slave error followed by a normal queued command
    push_cmd(1'b0, 12'h030, 32'h0, 0, 1'b1, 32'h0000_1234);
    push_cmd(1'b0, 12'h034, 32'h0, 1, 1'b0, 32'h0000_5678);
    drain();
`ifdef APB_MST_TIMEOUT_EN
    // wait limit: abort, then pready exactly at the limit cycle
    n_timeouts = 0;
    push_cmd(1'b0, 12'h040, 32'h0, 1000, 1'b0, 32'h1111_1111);
    drain();
    check(64'(n_timeouts), 64'd1, "timeout_abort");
    push_cmd(1'b0, 12'h044, 32'h0, TO_CYC, 1'b0, 32'h2222_2222);
    drain();
    check(64'(n_timeouts), 64'd1, "timeout_pready_wins");
`endif
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      push_cmd(1'($urandom), 12'($urandom), $urandom, int'($urandom_range(0, 4)),
               ($urandom_range(0, 3) == 0), $urandom);
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) tick();
    end
    drain();
    // reset during ACCESS wait states
    push_cmd(1'b1, 12'h050, 32'hCAFE_0001, 5, 1'b0, 32'h0);
    n = 0;
    while (!(prev_ph == 2 && acc_cyc == 3) && n < 50) begin
      tick();
      n++;
    end
    check({63'd0, (prev_ph == 2 && acc_cyc == 3)}, 64'd1, "mid_access_bound");
    #2 clkrst_b = 1'b0;
    #1;
    check({63'd0, psel}, 64'd0, "midrst_psel");
    check({63'd0, penable}, 64'd0, "midrst_penable");
    check({63'd0, rsp_vld}, 64'd0, "midrst_rsp_vld");
    check({63'd0, busy}, 64'd0, "midrst_busy");
    check({63'd0, cmd_rdy}, 64'd1, "midrst_cmd_rdy");
    pend.delete();
    prev_ph    = 0;
    done_prev  = 1'b0;
    acc_cyc    = 0;
    last_wdata = '0;
    @(negedge per_clk);
    clkrst_b = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    // traffic still works after the reset
    push_cmd(1'b0, 12'h060, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
